// File: rtl/seg_scan_mux_if.sv
// Bus bundle between the 7-segment decoder side and the scan driver.
// The master drives patterns and control; the slave (seg_scan_mux) drives the display side.
interface seg_scan_mux_if;
  logic [6:0] seg_H_in;
  logic [6:0] seg_L_in;
  logic       load;
  logic       enable;
  logic [6:0] seg_out;
  logic [1:0] an;
  logic       pending;
  logic       frame_tick;

  modport master (
    output seg_H_in, seg_L_in, load, enable,
    input  seg_out, an, pending, frame_tick
  );

  modport slave (
    input  seg_H_in, seg_L_in, load, enable,
    output seg_out, an, pending, frame_tick
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Two-digit time-multiplexed 7-segment scan driver.
// Active-low patterns are captured into a shadow register and swapped into the
// display register only at a frame boundary, so a displayed byte never tears.
// Each digit slot starts with a blanking interval to suppress ghosting.
module seg_scan_mux #(
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 500
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);

  localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK);
  localparam logic [6:0]    DARK_SEG  = 7'h7F;
  localparam logic [1:0]    DARK_AN   = 2'b11;

  typedef enum logic [1:0] {
    BLANK_H,
    SHOW_H,
    BLANK_L,
    SHOW_L
  } state_t;

  // With no blanking the blank states are skipped entirely, so each slot
  // begins directly in its SHOW state.
  localparam state_t FIRST_H = (BLANK == 0) ? SHOW_H : BLANK_H;
  localparam state_t FIRST_L = (BLANK == 0) ? SHOW_L : BLANK_L;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wrap;
  logic          boundary;

  logic [6:0]    shadow_H;
  logic [6:0]    shadow_L;
  logic [6:0]    disp_H;
  logic [6:0]    disp_L;

  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  // state and cnt describe the slot position handled at the next edge
  assign wrap     = (cnt == CNT_MAX);
  assign boundary = (state == SHOW_L) && wrap;

  // Slot counter and scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST_H;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Advance the slot counter and step through blank/show phases of each digit
  always_comb begin
    cnt_nxt   = wrap ? '0 : cnt + CNT_ONE;
    state_nxt = state;
    case (state)
      BLANK_H: if (cnt_nxt == BLANK_CNT) state_nxt = SHOW_H;
      SHOW_H:  if (wrap)                 state_nxt = FIRST_L;
      BLANK_L: if (cnt_nxt == BLANK_CNT) state_nxt = SHOW_L;
      SHOW_L:  if (wrap)                 state_nxt = FIRST_H;
      default:                           state_nxt = FIRST_H;
    endcase
  end

  // Decide what the bus shows for the position being processed; dark when disabled
  always_comb begin
    seg_nxt = DARK_SEG;
    an_nxt  = DARK_AN;
    if (bus.enable) begin
      case (state)
        SHOW_H: begin
          seg_nxt = disp_H;
          an_nxt  = 2'b01;
        end
        SHOW_L: begin
          seg_nxt = disp_L;
          an_nxt  = 2'b10;
        end
        default: begin
          seg_nxt = DARK_SEG;
          an_nxt  = DARK_AN;
        end
      endcase
    end
  end

  // Register the display outputs so segments and anodes change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_out <= DARK_SEG;
      bus.an      <= DARK_AN;
    end else begin
      bus.seg_out <= seg_nxt;
      bus.an      <= an_nxt;
    end
  end

  // Capture new patterns and hand them to the display only at a frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_H       <= DARK_SEG;
      shadow_L       <= DARK_SEG;
      disp_H         <= DARK_SEG;
      disp_L         <= DARK_SEG;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= boundary;
      if (bus.load) begin
        shadow_H <= bus.seg_H_in;
        shadow_L <= bus.seg_L_in;
        if (boundary) begin
          disp_H      <= bus.seg_H_in;
          disp_L      <= bus.seg_L_in;
          bus.pending <= 1'b0;
        end else begin
          bus.pending <= 1'b1;
        end
      end else if (boundary && bus.pending) begin
        disp_H      <= shadow_H;
        disp_L      <= shadow_L;
        bus.pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: the driver computes the expected outputs
// for every clock edge from frame-position arithmetic and queues them; the
// monitor pops one expectation after every edge taken out of reset.
module tb_seg_scan_mux;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int FRAME   = 2 * CLK_DIV;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       pend;
    logic       tick;
  } exp_t;

  logic clk;
  logic rst_n;

  seg_scan_mux_if bus ();

  seg_scan_mux #(
    .CLK_DIV (CLK_DIV),
    .BLANK   (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       exp_q[$];
  int         n_checks;
  int         n_pass;

  int         m_cycle;
  logic [6:0] m_shadow_H;
  logic [6:0] m_shadow_L;
  logic [6:0] m_disp_H;
  logic [6:0] m_disp_L;
  logic       m_pend;
  logic       cur_en;

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act === expv) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  task automatic modelReset();
    m_cycle    = 0;
    m_shadow_H = 7'h7F;
    m_shadow_L = 7'h7F;
    m_disp_H   = 7'h7F;
    m_disp_L   = 7'h7F;
    m_pend     = 1'b0;
  endtask

  // Reference: the frame is 2*CLK_DIV positions, first half high digit, each
  // half starting with BLANK dark positions; the last position is the boundary.
  task automatic modelStep(input logic ld, input logic [6:0] h, input logic [6:0] l, input logic en);
    exp_t e;
    int   pos;
    int   off;
    bit   hi;
    bit   bnd;
    pos   = m_cycle % FRAME;
    off   = pos % CLK_DIV;
    hi    = (pos < CLK_DIV);
    bnd   = (pos == FRAME - 1);
    e.seg = 7'h7F;
    e.an  = 2'b11;
    if (en && off >= BLANK) begin
      e.seg = hi ? m_disp_H : m_disp_L;
      e.an  = hi ? 2'b01 : 2'b10;
    end
    if (ld) begin
      m_shadow_H = h;
      m_shadow_L = l;
      if (bnd) begin
        m_disp_H = h;
        m_disp_L = l;
        m_pend   = 1'b0;
      end else begin
        m_pend = 1'b1;
      end
    end else if (bnd && m_pend) begin
      m_disp_H = m_shadow_H;
      m_disp_L = m_shadow_L;
      m_pend   = 1'b0;
    end
    e.pend = m_pend;
    e.tick = bnd;
    exp_q.push_back(e);
    m_cycle++;
  endtask

  // Called while the clock is low: drive inputs for the coming edge, queue the
  // expected result, then move to the next falling edge.
  task automatic applyStimulus(input logic ld, input logic [6:0] h, input logic [6:0] l, input logic en);
    bus.load     = ld;
    bus.seg_H_in = h;
    bus.seg_L_in = l;
    bus.enable   = en;
    modelStep(ld, h, l, en);
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'h55, 7'h2A, cur_en);
  endtask

  task automatic idleUntilPos(input int p);
    for (int i = 0; i < FRAME && (m_cycle % FRAME) != p; i++)
      applyStimulus(1'b0, 7'h33, 7'h44, cur_en);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_seg_out"},    {1'b0, bus.seg_out}, 8'h7F);
    checkOutput({tag, "_an"},         {6'd0, bus.an},      8'h03);
    checkOutput({tag, "_pending"},    {7'd0, bus.pending}, 8'h00);
    checkOutput({tag, "_frame_tick"}, {7'd0, bus.frame_tick}, 8'h00);
  endtask

  // Monitor: after every edge taken out of reset, pop and compare one expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("queue_underflow", 8'd0, 8'd1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("seg_out",    {1'b0, bus.seg_out},    {1'b0, e.seg});
          checkOutput("an",         {6'd0, bus.an},         {6'd0, e.an});
          checkOutput("pending",    {7'd0, bus.pending},    {7'd0, e.pend});
          checkOutput("frame_tick", {7'd0, bus.frame_tick}, {7'd0, e.tick});
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    n_checks     = 0;
    n_pass       = 0;
    cur_en       = 1'b1;
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.enable   = 1'b1;
    bus.seg_H_in = 7'h00;
    bus.seg_L_in = 7'h00;
    modelReset();

    // reset held, then released on a falling edge
    repeat (3) @(negedge clk);
    checkResetValues("reset_hold");
    rst_n = 1'b1;
    $display("[TB] reset released, idle frames");
    idleCycles(2 * FRAME);

    // load mid-frame at position 5
    $display("[TB] load mid-frame");
    idleUntilPos(5);
    applyStimulus(1'b1, 7'h12, 7'h4F, 1'b1);
    idleCycles(2 * FRAME);

    // load on the boundary edge
    $display("[TB] load on boundary edge");
    idleUntilPos(FRAME - 1);
    applyStimulus(1'b1, 7'h06, 7'h5B, 1'b1);
    idleCycles(FRAME + 3);

    // back-to-back loads, last one wins
    $display("[TB] back-to-back loads");
    idleUntilPos(3);
    applyStimulus(1'b1, 7'h01, 7'h01, 1'b1);
    applyStimulus(1'b1, 7'h00, 7'h00, 1'b1);
    idleCycles(2 * FRAME);

    // enable gating with a load inside the dark window
    $display("[TB] enable gating");
    idleUntilPos(4);
    cur_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 9) applyStimulus(1'b1, 7'h79, 7'h24, 1'b0);
      else        applyStimulus(1'b0, 7'h11, 7'h22, 1'b0);
    end
    cur_en = 1'b1;
    idleCycles(2 * FRAME);

    // async reset asserted between edges while the high digit is lit
    $display("[TB] async reset mid SHOW_H");
    idleUntilPos(BLANK + 2);
    applyStimulus(1'b1, 7'h7E, 7'h30, 1'b1);
    idleCycles(FRAME + 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("async_reset");
    repeat (2) @(negedge clk);
    checkResetValues("reset_hold2");
    checkOutput("queue_empty_at_reset", 8'(exp_q.size()), 8'd0);
    exp_q.delete();
    modelReset();
    rst_n = 1'b1;
    idleCycles(2 * FRAME);

    // randomized loads, values and enable stretches
    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic       ld;
      logic [6:0] h;
      logic [6:0] l;
      if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
      ld = ($urandom_range(0, 9) == 0);
      h  = 7'($urandom_range(0, 127));
      l  = 7'($urandom_range(0, 127));
      applyStimulus(ld, h, l, cur_en);
    end
    cur_en = 1'b1;
    idleCycles(2 * FRAME);

    checkOutput("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
